imem_loader: RTL and testbench

Instruction-memory loader for the pipelined CPU. It receives a framed byte stream over a valid/ready handshake and assembles 32-bit instruction words. It writes them sequentially into the instruction memory write port that sits opposite the fetch-side read port. While a load is in progress it holds the CPU pipeline in reset, so fetch never sees a partially written program.

---
 rtl/imem_loader.sv | 203 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: framed byte stream -> sequential 32-bit word writes,
// holding the CPU pipeline while loading. Define IMEM_LDR_CSUM_EN for a trailing XOR checksum byte.
module imem_loader #(
    parameter int         ADDR_W   = 8,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    output logic [7:0]        word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LDR_CSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_e;

    state_e              state_q;
    logic [7:0]          len_q;
    logic [1:0]          bidx_q;
    logic [23:0]         asm_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          cnt_q;
    logic                im_we_q;
    logic [ADDR_W-1:0]   im_addr_q;
    logic [31:0]         im_wdata_q;
    logic                hold_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
`ifdef IMEM_LDR_CSUM_EN
    logic [7:0]          csum_q;
`endif

    logic                xfer;
    logic [31:0]         word_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [7:0]          cnt_d;
    logic                start_go;
    logic                err_go;

    assign xfer     = in_valid & in_ready;
    assign word_d   = {asm_q, in_data};
    assign addr_d   = addr_q + 1'b1;
    assign cnt_d    = cnt_q + 8'd1;
    assign start_go = ld_start & ((state_q == S_IDLE) | (state_q == S_ERR));

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_HDR, S_LEN, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LDR_CSUM_EN
            S_CSUM:               in_ready = 1'b1;
`endif
            default:              in_ready = 1'b0;
        endcase
    end

    // Frame errors are decided on the accepted byte itself.
    always_comb begin
        err_go = 1'b0;
        if (xfer) begin
            case (state_q)
                S_HDR:   err_go = (in_data != HDR_BYTE);
                S_LEN:   err_go = (in_data == 8'd0);
`ifdef IMEM_LDR_CSUM_EN
                S_CSUM:  err_go = (in_data != csum_q);
`endif
                default: err_go = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= 8'd0;
            bidx_q     <= 2'd0;
            asm_q      <= 24'd0;
            addr_q     <= '0;
            cnt_q      <= 8'd0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'd0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LDR_CSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            im_we_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_HDR: begin
                    if (xfer && !err_go) state_q <= S_LEN;
                end
                S_LEN: begin
                    if (xfer) len_q <= in_data;
                    if (xfer && !err_go) state_q <= S_DATA;
                end
                S_DATA: begin
                    if (xfer) begin
                        asm_q  <= word_d[23:0];
                        bidx_q <= bidx_q + 2'd1;
`ifdef IMEM_LDR_CSUM_EN
                        csum_q <= csum_q ^ in_data;
`endif
                        // Fourth byte completes the word; the write strobe is registered with it.
                        if (bidx_q == 2'd3) begin
                            state_q    <= S_WRITE;
                            im_we_q    <= 1'b1;
                            im_addr_q  <= addr_q;
                            im_wdata_q <= word_d;
                        end
                    end
                end
                S_WRITE: begin
                    addr_q <= addr_d;
                    cnt_q  <= cnt_d;
                    if (cnt_d == len_q) begin
`ifdef IMEM_LDR_CSUM_EN
                        state_q <= S_CSUM;
`else
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= S_DATA;
                    end
                end
`ifdef IMEM_LDR_CSUM_EN
                S_CSUM: begin
                    if (xfer && !err_go) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                    hold_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                S_IDLE, S_ERR: ;
                default: begin
                    state_q <= S_IDLE;
                    hold_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase

            if (start_go) begin
                state_q <= S_HDR;
                hold_q  <= 1'b1;
                busy_q  <= 1'b1;
                err_q   <= 1'b0;
                cnt_q   <= 8'd0;
                bidx_q  <= 2'd0;
                addr_q  <= '0;
`ifdef IMEM_LDR_CSUM_EN
                csum_q  <= 8'd0;
`endif
            end

            // ERR keeps the CPU held until a good reload completes.
            if (err_go) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = hold_q;
    assign ld_busy  = busy_q;
    assign ld_done  = done_q;
    assign ld_err   = err_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level write scoreboard plus directed scenario checks.
module tb_imem_loader;
    localparam int AW = 2;
`ifdef IMEM_LDR_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ld_start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready, im_we, cpu_hold, ld_busy, ld_done, ld_err;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [7:0]    word_cnt;

    imem_loader #(.ADDR_W(AW), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .ld_start(ld_start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int nwr = 0, done_cnt = 0, done_cyc = 0, hs_cnt = 0, hdr_cyc = 0;
    logic [AW+31:0] exp_q[$];
    logic [31:0]    words_q[$];
    logic [7:0]     frame_q[$];
    logic [31:0]    wr_data_log[$];
    int             wr_addr_log[$];
    int             wr_cyc_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Write scoreboard: every strobe must match the next expected (address, word).
    initial begin
        logic [AW+31:0] e;
        forever begin
            @(negedge clk);
            if (in_valid && in_ready) hs_cnt++;
            if (ld_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_with_hold", 32'(cpu_hold), 32'd1);
            end
            if (im_we === 1'b1) begin
                nwr++;
                wr_data_log.push_back(im_wdata);
                wr_addr_log.push_back(int'(im_addr));
                wr_cyc_log.push_back(cyc);
                chk("we_hold_busy", 32'({cpu_hold, ld_busy}), 32'd3);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_we: addr %0h data %0h, required no write", im_addr, im_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("we_addr", 32'(im_addr), 32'(e[AW+31:32]));
                    chk("we_data", im_wdata, e[31:0]);
                end
            end
        end
    end

    // Model: bytes are the words MSB-first, word i lands at address i mod 2^AW.
    task automatic make_frame(input logic [7:0] len, input bit csum_bad);
        logic [7:0]    by;
        logic [7:0]    x;
        logic [AW-1:0] a;
        x = 8'd0;
        frame_q = {};
        frame_q.push_back(8'hA5);
        frame_q.push_back(len);
        for (int i = 0; i < words_q.size(); i++) begin
            for (int b = 3; b >= 0; b--) begin
                by = words_q[i][8*b +: 8];
                frame_q.push_back(by);
                x = x ^ by;
            end
            a = AW'(i % (1 << AW));
            exp_q.push_back({a, words_q[i]});
        end
        if (CS == 1) frame_q.push_back(csum_bad ? (x ^ 8'h08) : x);
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        hdr_cyc = cyc;
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_busy", 32'(ld_busy), 32'd1);
        chk("start_err_clr", 32'(ld_err), 32'd0);
        chk("start_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send_bytes(input int stop_after, input bit rnd);
        int idx = 0;
        int budget = 0;
        bit took;
        while (idx < frame_q.size() && idx != stop_after) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? frame_q[idx] : 8'($urandom);
            took = in_valid && in_ready;
            tick();
            if (took) idx++;
            budget++;
            if (budget > 400) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: %0d of %0d bytes taken", idx, frame_q.size());
                break;
            end
        end
        in_valid = 1'b0;
        ld_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        if (done_cnt == d0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: no ld_done within %0d cycles", budget);
        end
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({p, "_im_we"},    32'(im_we),    32'd0);
        chk({p, "_im_addr"},  32'(im_addr),  32'd0);
        chk({p, "_im_wdata"}, im_wdata,      32'd0);
        chk({p, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({p, "_ld_busy"},  32'(ld_busy),  32'd0);
        chk({p, "_ld_done"},  32'(ld_done),  32'd0);
        chk({p, "_ld_err"},   32'(ld_err),   32'd0);
        chk({p, "_word_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int w0, d0, hs0;

        // Reset with ld_start asserted: reset wins.
        reset = 1'b0;
        ld_start = 1'b1;
        repeat (3) tick();
        chk_reset_vals("rst");
        ld_start = 1'b0;
        reset = 1'b1;
        tick();
        chk("post_rst_hold", 32'(cpu_hold), 32'd0);
        chk("post_rst_busy", 32'(ld_busy), 32'd0);

        // Good two-word load, continuous valid, trailing byte offered.
        words_q = {32'h12345678, 32'h9ABCDEF0};
        make_frame(8'd2, 1'b0);
        w0 = nwr; d0 = done_cnt;
        start_load();
        send_bytes(-1, 1'b0);
        hs0 = hs_cnt;
        in_valid = 1'b1;
        in_data = 8'h77;
        wait_done(d0, 40);
        chk("A_done_lat", done_cyc - hdr_cyc, 2 + 5 * 2 + CS);
        tick();
        in_valid = 1'b0;
        chk("A_trailing_not_taken", hs_cnt - hs0, 0);
        chk("A_hold_low", 32'(cpu_hold), 32'd0);
        chk("A_busy_low", 32'(ld_busy), 32'd0);
        chk("A_word_cnt", 32'(word_cnt), 32'd2);
        chk("A_writes", nwr - w0, 2);
        chk("A_word0", wr_data_log[w0], 32'h12345678);
        chk("A_word1", wr_data_log[w0+1], 32'h9ABCDEF0);
        chk("A_addr1", wr_addr_log[w0+1], 1);
        chk("A_first_we_lat", wr_cyc_log[w0] - hdr_cyc, 6);
        chk("A_done_pulses", done_cnt - d0, 1);

        // Bad header, then a good reload from ERR.
        frame_q = {};
        frame_q.push_back(8'h5A);
        w0 = nwr;
        start_load();
        send_bytes(-1, 1'b0);
        tick();
        chk("B_err", 32'(ld_err), 32'd1);
        chk("B_hold", 32'(cpu_hold), 32'd1);
        chk("B_busy", 32'(ld_busy), 32'd0);
        chk("B_ready", 32'(in_ready), 32'd0);
        chk("B_writes", nwr - w0, 0);
        words_q = {32'hDEADBEEF};
        make_frame(8'd1, 1'b0);
        w0 = nwr; d0 = done_cnt;
        start_load();
        send_bytes(-1, 1'b0);
        wait_done(d0, 40);
        chk("B2_done_lat", done_cyc - hdr_cyc, 2 + 5 + CS);
        tick();
        chk("B2_err_clr", 32'(ld_err), 32'd0);
        chk("B2_hold_low", 32'(cpu_hold), 32'd0);
        chk("B2_word_cnt", 32'(word_cnt), 32'd1);
        chk("B2_word", wr_data_log[w0], 32'hDEADBEEF);
        chk("B2_addr", wr_addr_log[w0], 0);

        // LEN of zero.
        words_q = {};
        make_frame(8'd0, 1'b0);
        frame_q = {8'hA5, 8'h00};
        w0 = nwr; d0 = done_cnt;
        start_load();
        send_bytes(-1, 1'b0);
        tick();
        chk("L0_err", 32'(ld_err), 32'd1);
        chk("L0_hold", 32'(cpu_hold), 32'd1);
        chk("L0_writes", nwr - w0, 0);
        chk("L0_word_cnt", 32'(word_cnt), 32'd0);
        chk("L0_no_done", done_cnt - d0, 0);

`ifdef IMEM_LDR_CSUM_EN
        // Checksum mismatch: both words land, then ERR.
        words_q = {32'h12345678, 32'h9ABCDEF0};
        make_frame(8'd2, 1'b1);
        chk("CS_bad_byte", 32'(frame_q[frame_q.size()-1]), 32'h08);
        w0 = nwr; d0 = done_cnt;
        start_load();
        send_bytes(-1, 1'b0);
        tick();
        chk("CS_err", 32'(ld_err), 32'd1);
        chk("CS_hold", 32'(cpu_hold), 32'd1);
        chk("CS_writes", nwr - w0, 2);
        chk("CS_word_cnt", 32'(word_cnt), 32'd2);
        chk("CS_no_done", done_cnt - d0, 0);
`endif

        // Backpressure and address wrap; ld_start held mid-frame must be ignored.
        words_q = {};
        for (int i = 0; i < 5; i++)
            words_q.push_back({8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)});
        make_frame(8'd5, 1'b0);
        w0 = nwr; d0 = done_cnt;
        start_load();
        ld_start = 1'b1;
        send_bytes(-1, 1'b1);
        wait_done(d0, 60);
        tick();
        chk("BP_writes", nwr - w0, 5);
        chk("BP_word_cnt", 32'(word_cnt), 32'd5);
        chk("BP_addr3", wr_addr_log[w0+3], 3);
        chk("BP_addr4_wrap", wr_addr_log[w0+4], 0);
        chk("BP_word4", wr_data_log[w0+4], 32'h14243444);
        chk("BP_hold_low", 32'(cpu_hold), 32'd0);
        chk("BP_err", 32'(ld_err), 32'd0);
        chk("BP_sb_empty", exp_q.size(), 0);

        // Reset after the 6th data byte.
        words_q = {32'hA1A2A3A4, 32'hB1B2B3B4};
        make_frame(8'd2, 1'b0);
        w0 = nwr;
        start_load();
        send_bytes(8, 1'b0);
        exp_q = {};
        reset = 1'b0;
        tick();
        chk_reset_vals("mid");
        chk("mid_writes", nwr - w0, 1);
        chk("mid_word0", wr_data_log[w0], 32'hA1A2A3A4);
        tick();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA5;
        hs0 = hs_cnt;
        repeat (20) tick();
        in_valid = 1'b0;
        chk("mid_no_accept", hs_cnt - hs0, 0);
        chk("mid_no_more_we", nwr - w0, 1);
        chk("mid_hold_low", 32'(cpu_hold), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
